snake_segment_buffer: RTL and testbench
=======================================

Name: snake_segment_buffer

Overview:
- Circular-buffer store for the snake's body segments, with a logical head index, tracked length and grow/move semantics.
- After every step, a sequential self-collision scan compares the new head against all remaining body segments.
- Sits between the game-step controller, which issues steps, and the renderer, which reads segments by logical index.
- Successor to the minimal body RAM: coordinate widths, depth and initial length are parametrised.

Parameters:
- MAX_LEN, 256, segment capacity; power of two, 4..1024.
- IDX_W, $clog2(MAX_LEN), index/pointer width; length counter is IDX_W+1 bits.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- INIT_LEN, 3, segments written by init; 1..MAX_LEN.
- GRID_W, 160, grid width; used only with SNAKE_BOUNDS_CHECK_EN.
- GRID_H, 120, grid height; used only with SNAKE_BOUNDS_CHECK_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init  in  1  pulse; (re)initialise snake at init_x/init_y
- init_x  in  X_W  initial head x
- init_y  in  Y_W  initial head y
- step_valid  in  1  step request
- step_ready  out  1  block can accept a step
- step_x  in  X_W  new head x
- step_y  in  Y_W  new head y
- step_grow  in  1  keep tail (length +1)
- rd_idx  in  IDX_W  logical read index, 0 = head
- rd_x  out  X_W  registered read data x
- rd_y  out  Y_W  registered read data y
- rd_ok  out  1  registered: rd_idx < len at sample time
- len  out  IDX_W+1  current length
- head_x  out  X_W  current head x
- head_y  out  Y_W  current head y
- full  out  1  len == MAX_LEN
- scan_done  out  1  one-cycle pulse; collide/wall_hit valid
- collide  out  1  result of last scan, held until next accepted step
- wall_hit  out  1  bounds violation on last step, held until next accepted step

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; head_ptr=0, len=0; all registered outputs 0; step_ready=1.
  - Memory contents are undefined.
- States: IDLE, INIT, SCAN.
- IDLE: step_ready=1. A step is accepted when step_valid && step_ready.
- Init (from any state; init has priority over a same-cycle step):
  - Any scan in progress is aborted with no scan_done; collide and wall_hit are cleared.
  - Enter INIT. For k=0..INIT_LEN-1, one entry per cycle: segment k = (init_x-k mod 2^X_W, init_y).
  - head_ptr=0. len becomes INIT_LEN on the final INIT cycle, then return to IDLE.
  - step_ready=0 during INIT.
- Step accepted in cycle T:
  - head_ptr <= head_ptr-1 (mod MAX_LEN); the entry at the new head_ptr is written with (step_x, step_y).
  - len increments only if step_grow && !full, or if len==0; otherwise len is unchanged and the old tail drops out.
  - Grow while full: treated as a plain move; full stays 1.
  - collide is cleared at T. Enter SCAN at T+1; step_ready=0 while in SCAN.
- SCAN:
  - Compares logical index k (k=1..len-1) against the new head, one per cycle; index k is compared in cycle T+k.
  - Match: collide=1, scan_done pulses the cycle after the match, return to IDLE (early exit).
  - No match: scan_done pulses the cycle after index len-1 is compared, collide=0.
  - len<=1: scan_done at T+1, collide=0.
  - Because the tail is removed before the scan, moving into the cell the old tail occupied is legal.
- Read port:
  - Physical index = (head_ptr + rd_idx) mod MAX_LEN.
  - rd_x/rd_y/rd_ok register one cycle after rd_idx is sampled; the port is independent of SCAN.
  - rd_ok=0 when rd_idx >= len; rd_x/rd_y are don't-care in that case.
  - A read of the entry being written in the same cycle returns the old data.
- head_x/head_y: combinational from the entry at head_ptr; valid when len>0.

Optional Feature:
- Macro: SNAKE_BOUNDS_CHECK_EN.
- Defined:
  - A step with step_x >= GRID_W or step_y >= GRID_H is accepted but not written; len and head_ptr are unchanged.
  - wall_hit=1, collide=1, scan_done pulses at T+1, no scan is performed.
- Undefined: no bounds checking; wall_hit is tied 0.

Test Plan:
- Reset, then init with (10,5), INIT_LEN=3 → 3 INIT cycles; then len=3; rd_idx 0/1/2 return (10,5)/(9,5)/(8,5) one cycle later; rd_idx=3 gives rd_ok=0.
- Move step (11,5), grow=0 → len=3, head=(11,5), tail=(9,5); scan_done at T+3, collide=0.
- Build a length-5 snake, then steer the head onto the segment at index 3 → collide=1, scan_done early at T+4; step_ready stays low until scan_done.
- Fill to MAX_LEN=4 with grow steps, then one more grow → full=1, len stays 4, index 0 holds the new head, the oldest segment is dropped.
- Assert init during SCAN and a same-cycle step → no scan_done, INIT entered, step ignored; async rst_n low mid-INIT → len=0, step_ready=1 immediately.
- With SNAKE_BOUNDS_CHECK_EN: step (160,5) → wall_hit=1, collide=1, scan_done at T+1, len/head unchanged; without the macro, the same step is written and wall_hit=0.

Source files
------------

// File: rtl/snake_segment_buffer.sv
// Circular segment store for the snake body with grow/move steps and a sequential self-collision scan.
// Optional wall checking is enabled by defining SNAKE_BOUNDS_CHECK_EN.
module snake_segment_buffer #(
  parameter int MAX_LEN  = 256,
  parameter int IDX_W    = $clog2(MAX_LEN),
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [X_W-1:0]   init_x,
  input  logic [Y_W-1:0]   init_y,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [X_W-1:0]   step_x,
  input  logic [Y_W-1:0]   step_y,
  input  logic             step_grow,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_ok,
  output logic [IDX_W:0]   len,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic             full,
  output logic             scan_done,
  output logic             collide,
  output logic             wall_hit
);
  localparam int SEG_W = X_W + Y_W;
  localparam logic [IDX_W-1:0] INIT_LAST  = IDX_W'(INIT_LEN - 1);
  localparam logic [IDX_W:0]   INIT_LEN_V = (IDX_W+1)'(INIT_LEN);
  localparam logic [IDX_W:0]   FULL_LEN   = (IDX_W+1)'(MAX_LEN);
  localparam logic [IDX_W:0]   LEN_ONE    = 1;
  localparam logic [IDX_W-1:0] PTR_ONE    = 1;
  localparam logic [X_W:0]     GW         = (X_W+1)'(GRID_W);
  localparam logic [Y_W:0]     GH         = (Y_W+1)'(GRID_H);
`ifdef SNAKE_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, INIT, SCAN} state_t;

  state_t           state;
  logic [SEG_W-1:0] mem [MAX_LEN];
  logic [IDX_W-1:0] head_ptr, init_k, scan_k;
  logic [IDX_W:0]   len_q;
  logic [X_W-1:0]   ix;
  logic [Y_W-1:0]   iy;

  logic             step_acc, oob, grows, scan_hit, scan_last;
  logic [IDX_W-1:0] new_ptr;
  logic [IDX_W:0]   len_next;

  assign len        = len_q;
  assign full       = (len_q == FULL_LEN);
  assign step_ready = (state == IDLE);
  assign {head_x, head_y} = mem[head_ptr];

  assign step_acc  = step_valid && (state == IDLE) && !init;
  assign oob       = BOUNDS_EN && (({1'b0, step_x} >= GW) || ({1'b0, step_y} >= GH));
  assign new_ptr   = head_ptr - PTR_ONE;
  assign grows     = (step_grow && !full) || (len_q == '0);
  assign len_next  = grows ? len_q + LEN_ONE : len_q;
  // the scan runs after head_ptr has moved, so mem[head_ptr] is already the new head
  assign scan_hit  = (mem[head_ptr + scan_k] == mem[head_ptr]);
  assign scan_last = ({1'b0, scan_k} == len_q - LEN_ONE);

  always_ff @(posedge clk) begin
    if (state == INIT && !init)
      mem[init_k] <= {ix - X_W'(init_k), iy};
    else if (step_acc && !oob)
      mem[new_ptr] <= {step_x, step_y};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      head_ptr  <= '0;
      len_q     <= '0;
      init_k    <= '0;
      scan_k    <= '0;
      ix        <= '0;
      iy        <= '0;
      rd_x      <= '0;
      rd_y      <= '0;
      rd_ok     <= 1'b0;
      scan_done <= 1'b0;
      collide   <= 1'b0;
      wall_hit  <= 1'b0;
    end else begin
      scan_done    <= 1'b0;
      rd_ok        <= ({1'b0, rd_idx} < len_q);
      {rd_x, rd_y} <= mem[head_ptr + rd_idx];
      if (init) begin
        state    <= INIT;
        init_k   <= '0;
        head_ptr <= '0;
        len_q    <= '0;
        ix       <= init_x;
        iy       <= init_y;
        collide  <= 1'b0;
        wall_hit <= 1'b0;
      end else begin
        case (state)
          IDLE: if (step_valid) begin
            collide  <= 1'b0;
            wall_hit <= 1'b0;
            if (oob) begin
              wall_hit  <= 1'b1;
              collide   <= 1'b1;
              scan_done <= 1'b1;
            end else begin
              head_ptr <= new_ptr;
              len_q    <= len_next;
              if (len_next == LEN_ONE) scan_done <= 1'b1;
              else begin
                state  <= SCAN;
                scan_k <= PTR_ONE;
              end
            end
          end
          INIT: begin
            if (init_k == INIT_LAST) begin
              len_q <= INIT_LEN_V;
              state <= IDLE;
            end else init_k <= init_k + PTR_ONE;
          end
          SCAN: begin
            if (scan_hit || scan_last) begin
              collide   <= scan_hit;
              scan_done <= 1'b1;
              state     <= IDLE;
            end else scan_k <= scan_k + PTR_ONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_snake_segment_buffer.sv
// Scoreboard bench for snake_segment_buffer: queue-based body model, directed cases then random steps.
module tb_snake_segment_buffer;
  localparam int MAX_LEN = 8, IDX_W = 3, X_W = 8, Y_W = 7, INIT_LEN = 3;

  logic clk = 0, rst_n = 0, init = 0, step_valid = 0, step_grow = 0;
  logic [X_W-1:0] init_x = 0, step_x = 0;
  logic [Y_W-1:0] init_y = 0, step_y = 0;
  logic [IDX_W-1:0] rd_idx = 0;
  logic step_ready, rd_ok, full, scan_done, collide, wall_hit;
  logic [X_W-1:0] rd_x, head_x;
  logic [Y_W-1:0] rd_y, head_y;
  logic [IDX_W:0] len;

  snake_segment_buffer #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W), .X_W(X_W), .Y_W(Y_W), .INIT_LEN(INIT_LEN),
                         .GRID_W(160), .GRID_H(120)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .init_x(init_x), .init_y(init_y),
    .step_valid(step_valid), .step_ready(step_ready), .step_x(step_x), .step_y(step_y),
    .step_grow(step_grow), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_ok(rd_ok),
    .len(len), .head_x(head_x), .head_y(head_y), .full(full), .scan_done(scan_done),
    .collide(collide), .wall_hit(wall_hit));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int x; int y;} seg_t;
  typedef struct {int due; bit col; bit wall;} exp_t;
  seg_t body[$];
  exp_t expq[$];
  int vectors = 0, errors = 0;
  bit in_init = 0, last_col = 0, last_wall = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: scan results against the queued expectations, handshake otherwise
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (scan_done) begin
        if (expq.size() == 0) check("spurious_scan_done", scan_done, 0);
        else begin
          e = expq.pop_front();
          check("scan_done_cycle", cyc, e.due);
          check("collide", collide, e.col);
          check("wall_hit", wall_hit, e.wall);
        end
      end else if (expq.size() != 0 && cyc > expq[0].due) begin
        check("scan_done_missing", scan_done, 1);
        void'(expq.pop_front());
      end else if (!in_init) check("step_ready", step_ready, expq.size() == 0);
    end
  end

  task automatic do_step(int x, int y, bit g);
    int n = 0, lat = 1, hit = 0;
    bit keep;
    while (!step_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!step_ready) check("step_ready_timeout", step_ready, 1);
    step_x = X_W'(x); step_y = Y_W'(y); step_grow = g; step_valid = 1;
    @(posedge clk); #1;
    step_valid = 0;
    last_col = 0; last_wall = 0;
`ifdef SNAKE_BOUNDS_CHECK_EN
    if (x >= 160 || y >= 120) begin
      last_col = 1; last_wall = 1;
      expq.push_back('{cyc, 1'b1, 1'b1});
      return;
    end
`endif
    keep = (g && body.size() < MAX_LEN) || body.size() == 0;
    body.push_front('{x, y});
    if (!keep) void'(body.pop_back());
    if (body.size() > 1) begin
      lat = body.size();
      for (int k = 1; k < body.size(); k++)
        if (hit == 0 && body[k] == body[0]) begin hit = k; lat = k + 1; end
    end
    last_col = (hit != 0);
    expq.push_back('{cyc + lat - 1, last_col, 1'b0});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (expq.size() != 0) begin check("scan_timeout", expq.size(), 0); expq.delete(); end
  endtask

  task automatic do_init(int x, int y, bit with_step);
    expq.delete();
    in_init = 1;
    init_x = X_W'(x); init_y = Y_W'(y); init = 1;
    if (with_step) begin step_x = X_W'(x + 1); step_y = Y_W'(y); step_grow = 1; step_valid = 1; end
    @(posedge clk); #1;
    init = 0; step_valid = 0;
    for (int k = 0; k < INIT_LEN; k++) begin
      check("init_busy", step_ready, 0);
      @(posedge clk); #1;
    end
    check("init_done_ready", step_ready, 1);
    in_init = 0; last_col = 0; last_wall = 0;
    body.delete();
    for (int k = 0; k < INIT_LEN; k++) body.push_back('{(x - k) & 255, y});
  endtask

  task automatic rd_check(int idx);
    rd_idx = IDX_W'(idx);
    @(posedge clk); #1;
    check("rd_ok", rd_ok, idx < body.size());
    if (idx < body.size()) begin
      check("rd_x", rd_x, body[idx].x);
      check("rd_y", rd_y, body[idx].y);
    end
  endtask

  task automatic state_check();
    check("len", len, body.size());
    check("full", full, body.size() == MAX_LEN);
    check("collide_held", collide, last_col);
    check("wall_hit_held", wall_hit, last_wall);
    if (body.size() > 0) begin
      check("head_x", head_x, body[0].x);
      check("head_y", head_y, body[0].y);
    end
  endtask

  initial begin
    #1;
    check("rst_len", len, 0);
    check("rst_ready", step_ready, 1);
    check("rst_rd_ok", rd_ok, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_collide", collide, 0);
    check("rst_wall_hit", wall_hit, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    do_init(10, 5, 0);
    state_check();
    for (int i = 0; i < 4; i++) rd_check(i);

    do_step(11, 5, 0);
    rd_check(2);
    wait_idle(); state_check();
    do_step(12, 5, 1); wait_idle();
    do_step(12, 6, 1); wait_idle(); state_check();
    do_step(11, 5, 0); wait_idle(); state_check();

    do_step(160, 5, 0); wait_idle(); state_check();

    do_init(20, 3, 0);
    for (int i = 0; i < 6; i++) begin do_step(21 + i, 3, 1); wait_idle(); end
    state_check();
    for (int i = 0; i < MAX_LEN; i++) rd_check(i);

    do_step(30, 3, 0);
    do_init(40, 7, 1);
    state_check();
    for (int i = 0; i < 4; i++) rd_check(i);

    do_init(1, 2, 1);
    state_check();
    for (int i = 0; i < 4; i++) rd_check(i);

    in_init = 1; init_x = 50; init_y = 9; init = 1;
    @(posedge clk); #1; init = 0;
    @(posedge clk); #1;
    rst_n = 0; #1;
    body.delete(); expq.delete(); last_col = 0; last_wall = 0;
    check("midinit_rst_len", len, 0);
    check("midinit_rst_ready", step_ready, 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    in_init = 0;
    do_step(7, 7, 0); wait_idle(); state_check();

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 24) == 0) do_init($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 1));
      else begin
        do_step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
        rd_check($urandom_range(0, MAX_LEN - 1));
        wait_idle();
      end
      state_check();
    end

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
